turn_commit: RTL and testbench

- Downstream stage of the selection/adder block.
- Owns the 40-bit game status register (10 objects × 4 bits; row 0 at bit offsets 0–16 belongs to player 0, row 1 at offsets 20–36 belongs to player 1).
- Validates and commits each move result (index, value, draw flags), toggles the active player, counts draw moves, and detects win/draw end-of-game.
- Its status and player outputs feed back into the selection block.

---
 rtl/turn_commit.sv | 163 ++++++++++++++++
 tb/tb_turn_commit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/turn_commit.sv
// Commit stage for the two-player game: validates a move, writes it into the
// 40-bit object status register, toggles the player and detects end of game.
module turn_commit #(
  parameter logic [3:0] INIT_VALUE = 4'd1,
  parameter logic [3:0] DRAW_LIMIT = 4'd6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  num,
  input  logic        new_game,
  input  logic        move_valid,
  // Six bits so that row-1 offsets 32 and 36 are addressable.
  input  logic [5:0]  move_index,
  input  logic [3:0]  move_value,
  input  logic        p1_draw,
  input  logic        p2_draw,
  output logic        move_ready,
  output logic [39:0] status,
  output logic        player,
  output logic        move_error,
  output logic        game_over,
  output logic [1:0]  result,
  output logic [3:0]  draw_count
);

  typedef enum logic [2:0] {IDLE, CHECK, WRITE, EVAL, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  n_eff;
  logic [5:0]  idx_q;
  logic [3:0]  val_q;
  logic        draw_q;
  logic        legal_q;
  logic        legal;
  logic [3:0]  obj;
  logic [3:0]  slot;
  logic        obj_row;
  logic        row0_zero, row1_zero, end_game;

  assign n_eff = ((num == 3'd0) || (num > 3'd5)) ? 3'd5 : num;

  function automatic logic [39:0] init_status(input logic [2:0] n);
    logic [39:0] s;
    s = '0;
    for (int k = 0; k < 5; k++) begin
      if (k < int'(n)) begin
        s[4*k +: 4]     = INIT_VALUE;
        s[4*(k+5) +: 4] = INIT_VALUE;
      end
    end
    return s;
  endfunction

  // Handshake: a move is taken on a rising edge where move_valid & move_ready;
  // move_valid while move_ready is low is dropped without any error.
  assign move_ready = (state_q == IDLE) && !game_over;

  always_comb begin
    obj     = idx_q[5:2];
    obj_row = (obj >= 4'd5);
    slot    = obj_row ? (obj - 4'd5) : obj;
    legal   = (idx_q[1:0] == 2'b00) && (idx_q <= 6'd36) &&
              (slot < {1'b0, n_eff}) && (obj_row == player) &&
              (val_q <= 4'd9);
  end

  // Only active objects take part in the win check.
  always_comb begin
    row0_zero = 1'b1;
    row1_zero = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k < int'(n_eff)) begin
        if (status[4*k +: 4] != 4'd0)     row0_zero = 1'b0;
        if (status[4*(k+5) +: 4] != 4'd0) row1_zero = 1'b0;
      end
    end
    end_game = row0_zero || row1_zero || (draw_count >= DRAW_LIMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (new_game) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (move_valid && move_ready) state_d = CHECK;
        CHECK:   state_d = WRITE;
        WRITE:   state_d = legal_q ? EVAL : IDLE;
        EVAL:    state_d = end_game ? DONE : IDLE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status     <= init_status(n_eff);
      player     <= 1'b0;
      move_error <= 1'b0;
      game_over  <= 1'b0;
      result     <= 2'b00;
      draw_count <= 4'd0;
      idx_q      <= '0;
      val_q      <= '0;
      draw_q     <= 1'b0;
      legal_q    <= 1'b0;
    end else begin
      move_error <= 1'b0;
      if (new_game) begin
        status     <= init_status(n_eff);
        player     <= 1'b0;
        game_over  <= 1'b0;
        result     <= 2'b00;
        draw_count <= 4'd0;
        legal_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (move_valid && move_ready) begin
              idx_q  <= move_index;
              val_q  <= move_value;
              draw_q <= player ? p2_draw : p1_draw;
            end
          end
          CHECK: legal_q <= legal;
          WRITE: begin
            if (legal_q) begin
              status[{idx_q[5:2], 2'b00} +: 4] <= val_q;
              player <= ~player;
              if (draw_q)
                draw_count <= (draw_count == 4'd15) ? 4'd15 : draw_count + 4'd1;
              else
                draw_count <= 4'd0;
            end else begin
              move_error <= 1'b1;
            end
          end
          EVAL: begin
            // Row 0 is tested first so a double wipe-out goes to player 0.
            if (row0_zero) begin
              result    <= 2'b01;
              game_over <= 1'b1;
            end else if (row1_zero) begin
              result    <= 2'b10;
              game_over <= 1'b1;
            end else if (draw_count >= DRAW_LIMIT) begin
              result    <= 2'b11;
              game_over <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_turn_commit.sv
// Self-checking bench for turn_commit: directed scenarios plus random games
// compared against an array-based model of the game rules.
module tb_turn_commit;

  localparam int DRAW_LIM = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  num = 3'd5;
  logic        new_game = 1'b0;
  logic        move_valid = 1'b0;
  logic [5:0]  move_index = '0;
  logic [3:0]  move_value = '0;
  logic        p1_draw = 1'b0;
  logic        p2_draw = 1'b0;
  logic        move_ready;
  logic [39:0] status;
  logic        player;
  logic        move_error;
  logic        game_over;
  logic [1:0]  result;
  logic [3:0]  draw_count;

  turn_commit #(.INIT_VALUE(4'd1), .DRAW_LIMIT(4'(DRAW_LIM))) dut (
    .clk(clk), .rst_n(rst_n), .num(num), .new_game(new_game),
    .move_valid(move_valid), .move_index(move_index), .move_value(move_value),
    .p1_draw(p1_draw), .p2_draw(p2_draw), .move_ready(move_ready),
    .status(status), .player(player), .move_error(move_error),
    .game_over(game_over), .result(result), .draw_count(draw_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [39:0] exp_q[$];

  // Reference model of the game
  int   m_val[10];
  bit   m_player;
  int   m_draw;
  bit   m_over;
  logic [1:0] m_res;

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int eff_n();
    return (num == 0 || num > 5) ? 5 : int'(num);
  endfunction

  function automatic logic [39:0] model_status();
    logic [39:0] s;
    for (int k = 0; k < 10; k++) s[4*k +: 4] = 4'(m_val[k]);
    return s;
  endfunction

  task automatic model_init();
    int n;
    n = eff_n();
    for (int k = 0; k < 10; k++) m_val[k] = ((k % 5) < n) ? 1 : 0;
    m_player = 0;
    m_draw   = 0;
    m_over   = 0;
    m_res    = 2'b00;
  endtask

  task automatic model_eval();
    int n;
    bit z0, z1;
    n  = eff_n();
    z0 = 1;
    z1 = 1;
    for (int s = 0; s < n; s++) begin
      if (m_val[s] != 0)     z0 = 0;
      if (m_val[5 + s] != 0) z1 = 0;
    end
    if (z0)                     begin m_res = 2'b01; m_over = 1; end
    else if (z1)                begin m_res = 2'b10; m_over = 1; end
    else if (m_draw >= DRAW_LIM) begin m_res = 2'b11; m_over = 1; end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_status"}, status, model_status());
    check({tag, "_player"}, player, m_player);
    check({tag, "_over"}, game_over, m_over);
    check({tag, "_result"}, result, m_res);
    check({tag, "_draw"}, draw_count, 4'(m_draw));
    check({tag, "_ready"}, move_ready, !m_over);
  endtask

  task automatic do_new_game(input logic [2:0] n);
    @(negedge clk);
    num      = n;
    new_game = 1'b1;
    @(posedge clk);
    #1 new_game = 1'b0;
    model_init();
    check_state("new_game");
  endtask

  task automatic do_move(input logic [5:0] idx, input logic [3:0] val,
                         input logic d1, input logic d2);
    bit acc, err, mover_draw;
    int obj;
    @(negedge clk);
    check("ready_before", move_ready, !m_over);
    move_valid = 1'b1;
    move_index = idx;
    move_value = val;
    p1_draw    = d1;
    p2_draw    = d2;
    @(posedge clk);
    #1 move_valid = 1'b0;
    p1_draw = 1'b0;
    p2_draw = 1'b0;
    acc = !m_over;
    err = 0;
    if (acc) begin
      obj = int'(idx) / 4;
      if ((idx % 4) != 0 || idx > 36 || (obj % 5) >= eff_n() ||
          (obj / 5) != int'(m_player) || val > 9)
        err = 1;
      if (!err) begin
        mover_draw = m_player ? d2 : d1;
        m_val[obj] = int'(val);
        m_player   = !m_player;
        m_draw     = mover_draw ? ((m_draw < 15) ? m_draw + 1 : 15) : 0;
      end
    end
    exp_q.push_back(model_status());
    @(posedge clk);
    @(posedge clk);
    #1;
    check("move_error", move_error, err);
    check("status_t2", status, exp_q.pop_front());
    check("player_t2", player, m_player);
    check("draw_t2", draw_count, 4'(m_draw));
    if (acc && !err) model_eval();
    @(posedge clk);
    #1;
    check("error_clear", move_error, 1'b0);
    check("over_t3", game_over, m_over);
    check("result_t3", result, m_res);
    check("ready_t3", move_ready, !m_over);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ridx;
    logic [3:0] rval;
    int slot;

    // Reset state
    rst_n = 1'b0;
    num   = 3'd5;
    #12;
    model_init();
    check("reset_status_const", status, 40'h1111111111);
    check_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Illegal moves by player 0: wrong row, misaligned, value too large
    do_move(6'd24, 4'd3, 1'b0, 1'b0);
    do_move(6'd6, 4'd3, 1'b0, 1'b0);
    do_move(6'd8, 4'd12, 1'b0, 1'b0);
    do_move(6'd40, 4'd2, 1'b0, 1'b0);
    // Legal move
    do_move(6'd8, 4'd7, 1'b0, 1'b0);
    check("idx8_nibble", status[11:8], 4'd7);

    // num=2 player 0 win, later move ignored, restart
    do_new_game(3'd2);
    do_move(6'd8, 4'd0, 1'b0, 1'b0);   // slot 2 inactive with num=2
    do_move(6'd0, 4'd0, 1'b0, 1'b0);
    do_move(6'd20, 4'd5, 1'b0, 1'b0);
    do_move(6'd4, 4'd0, 1'b0, 1'b0);
    check("win_result", result, 2'b01);
    do_move(6'd24, 4'd0, 1'b0, 1'b0);
    do_new_game(3'd2);

    // Draw counting: non-mover flag is ignored, non-draw move clears count
    do_new_game(3'd5);
    do_move(6'd0, 4'd3, 1'b1, 1'b0);
    do_move(6'd20, 4'd3, 1'b1, 1'b0);
    do_move(6'd4, 4'd3, 1'b1, 1'b0);
    do_move(6'd24, 4'd3, 1'b0, 1'b1);
    check("draw_result", result, 2'b11);

    // Asynchronous reset while the move is in the write state
    do_new_game(3'd4);
    @(negedge clk);
    move_valid = 1'b1;
    move_index = 6'd0;
    move_value = 4'd6;
    @(posedge clk);
    #1 move_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_init();
    check_state("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_state("after_reset");
    check("after_reset_err", move_error, 1'b0);

    // new_game together with move_valid: restart wins, move dropped
    do_move(6'd4, 4'd9, 1'b0, 1'b0);
    @(negedge clk);
    new_game   = 1'b1;
    move_valid = 1'b1;
    move_index = 6'd0;
    move_value = 4'd3;
    @(posedge clk);
    #1 new_game = 1'b0;
    move_valid = 1'b0;
    model_init();
    check_state("ng_with_move");
    repeat (3) @(posedge clk);
    #1;
    check_state("ng_with_move_later");
    check("ng_with_move_err", move_error, 1'b0);

    // Random games
    for (int i = 0; i < 160; i++) begin
      if (m_over) begin
        do_move(6'($urandom_range(0, 36)), 4'($urandom_range(0, 9)), 1'b0, 1'b0);
        do_new_game(3'($urandom_range(0, 7)));
      end
      if ($urandom_range(0, 9) == 0) begin
        @(negedge clk);
        num = 3'($urandom_range(0, 7));
      end
      slot = $urandom_range(0, eff_n() - 1);
      ridx = 6'((int'(m_player) * 5 + slot) * 4);
      if ($urandom_range(0, 7) == 0) ridx = 6'($urandom_range(0, 63));
      rval = ($urandom_range(0, 9) < 4) ? 4'd0 : 4'($urandom_range(1, 9));
      if ($urandom_range(0, 15) == 0) rval = 4'($urandom_range(10, 15));
      do_move(ridx, rval, ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
